// File: rtl/ff_bank_core_if.sv
// Control and status bundle for the multi-mode flip-flop bank.
// master drives mode/data/strobes; slave (the core) returns q, q_n, cnt and sr_err.
interface ff_bank_core_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             ena;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             cnt_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [CNT_W-1:0] cnt;
  logic             sr_err;

  modport master (
    output ena, mode, a, b, load, load_val, cnt_clr,
    input  q, q_n, cnt, sr_err
  );

  modport slave (
    input  ena, mode, a, b, load, load_val, cnt_clr,
    output q, q_n, cnt, sr_err
  );
endinterface

// File: rtl/ff_bank_core.sv
// WIDTH-channel T/D/JK/SR flip-flop bank with input synchronisers, parallel load, change counter, sticky SR flag.
// a/b reach q after SYNC_STAGES+1 edges, load after 1 edge; no backpressure (ena=0 simply freezes state).
module ff_bank_core #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input logic          clk,
  input logic          rst_n,
  ff_bank_core_if.slave bus
);

  localparam logic [1:0] MODE_T  = 2'b00;
  localparam logic [1:0] MODE_D  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  logic [WIDTH-1:0] as;
  logic [WIDTH-1:0] bs;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign as = bus.a;
      assign bs = bus.b;
    end else begin : g_sync
      // Stage 0 sits in the low WIDTH bits; the oldest sample is the top slice.
      logic [SYNC_STAGES*WIDTH-1:0] a_sync_q, a_sync_d;
      logic [SYNC_STAGES*WIDTH-1:0] b_sync_q, b_sync_d;

      always_comb begin
        a_sync_d = a_sync_q;
        b_sync_d = b_sync_q;
        a_sync_d[WIDTH-1:0] = bus.a;
        b_sync_d[WIDTH-1:0] = bus.b;
        for (int s = 1; s < SYNC_STAGES; s++) begin
          a_sync_d[s*WIDTH +: WIDTH] = a_sync_q[(s-1)*WIDTH +: WIDTH];
          b_sync_d[s*WIDTH +: WIDTH] = b_sync_q[(s-1)*WIDTH +: WIDTH];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_sync_q <= '0;
          b_sync_q <= '0;
        end else begin
          a_sync_q <= a_sync_d;
          b_sync_q <= b_sync_d;
        end
      end

      assign as = a_sync_q[(SYNC_STAGES-1)*WIDTH +: WIDTH];
      assign bs = b_sync_q[(SYNC_STAGES-1)*WIDTH +: WIDTH];
    end
  endgenerate

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sr_err_q, sr_err_d;
  logic [WIDTH-1:0] nxt;
  logic             sr_illegal;

  always_comb begin
    nxt        = q_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    sr_err_d   = sr_err_q;
    sr_illegal = 1'b0;

    for (int i = 0; i < WIDTH; i++) begin
      case (bus.mode)
        MODE_T:  nxt[i] = q_q[i] ^ as[i];
        MODE_D:  nxt[i] = as[i];
        MODE_JK: begin
          case ({as[i], bs[i]})
            2'b01:   nxt[i] = 1'b0;
            2'b10:   nxt[i] = 1'b1;
            2'b11:   nxt[i] = ~q_q[i];
            default: nxt[i] = q_q[i];
          endcase
        end
        default: begin
          case ({as[i], bs[i]})
            2'b01:   nxt[i] = 1'b0;
            2'b10:   nxt[i] = 1'b1;
            default: nxt[i] = q_q[i];
          endcase
        end
      endcase
    end

    if (bus.load) begin
      nxt = bus.load_val;
    end else if (bus.mode == MODE_SR) begin
      sr_illegal = |(as & bs);
    end

    if (bus.ena) begin
      q_d = nxt;
      if ((nxt != q_q) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (sr_illegal) begin
        sr_err_d = 1'b1;
      end
    end

    // Clear wins over increment/set and works with ena low; q is unaffected.
    if (bus.cnt_clr) begin
      cnt_d    = '0;
      sr_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q      <= '0;
      cnt_q    <= '0;
      sr_err_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      sr_err_q <= sr_err_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.q_n    = ~q_q;
  assign bus.cnt    = cnt_q;
  assign bus.sr_err = sr_err_q;

endmodule

// File: tb/tb_ff_bank_core.sv
// Directed self-checking bench for ff_bank_core at WIDTH=4, SYNC_STAGES=2, CNT_W=8.
module tb_ff_bank_core;
  localparam int WIDTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ff_bank_core_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus();

  ff_bank_core #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.ena = 1'b1; bus.mode = 2'b00; bus.a = '0; bus.b = '0;
    bus.load = 1'b0; bus.load_val = '0; bus.cnt_clr = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.ena = 1'b1; bus.mode = 2'b01; bus.a = 4'hF; bus.b = '0;
    bus.load = 1'b0; bus.load_val = '0; bus.cnt_clr = 1'b0;
    rst_n = 1'b0;
    tick(3);
    n_cmp++; if (bus.q !== 4'h0) begin n_bad++; $display("FAIL rst_q: got %h want 0", bus.q); end
    n_cmp++; if (bus.q_n !== 4'hF) begin n_bad++; $display("FAIL rst_qn: got %h want F", bus.q_n); end
    n_cmp++; if (bus.cnt !== 8'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", bus.cnt); end
    n_cmp++; if (bus.sr_err !== 1'b0) begin n_bad++; $display("FAIL rst_srerr: got %b want 0", bus.sr_err); end
    rst_n = 1'b1;
    tick(2);
    n_cmp++; if (bus.q !== 4'h0) begin n_bad++; $display("FAIL rel_q_edge2: got %h want 0", bus.q); end
    tick(1);
    n_cmp++; if (bus.q !== 4'hF) begin n_bad++; $display("FAIL rel_q_edge3: got %h want F", bus.q); end
    n_cmp++; if (bus.cnt !== 8'd1) begin n_bad++; $display("FAIL rel_cnt_edge3: got %0d want 1", bus.cnt); end
    // asynchronous assertion mid-cycle
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.q !== 4'h0) begin n_bad++; $display("FAIL async_rst_q: got %h want 0", bus.q); end
    n_cmp++; if (bus.cnt !== 8'd0) begin n_bad++; $display("FAIL async_rst_cnt: got %0d want 0", bus.cnt); end
    tick(1);
    rst_n = 1'b1;
    tick(2);
    n_cmp++; if (bus.q !== 4'h0) begin n_bad++; $display("FAIL sync_flush_q: got %h want 0", bus.q); end
  endtask

  task automatic test_t_mode();
    do_reset();
    bus.mode = 2'b00; bus.a = 4'b0101;
    tick(2);
    n_cmp++; if (bus.q !== 4'b0000) begin n_bad++; $display("FAIL t_q_e2: got %b want 0000", bus.q); end
    tick(1);
    n_cmp++; if (bus.q !== 4'b0101) begin n_bad++; $display("FAIL t_q_e3: got %b want 0101", bus.q); end
    n_cmp++; if (bus.cnt !== 8'd1) begin n_bad++; $display("FAIL t_cnt_e3: got %0d want 1", bus.cnt); end
    tick(1);
    n_cmp++; if (bus.q !== 4'b0000) begin n_bad++; $display("FAIL t_q_e4: got %b want 0000", bus.q); end
    tick(1);
    n_cmp++; if (bus.q !== 4'b0101) begin n_bad++; $display("FAIL t_q_e5: got %b want 0101", bus.q); end
    tick(1);
    n_cmp++; if (bus.q !== 4'b0000) begin n_bad++; $display("FAIL t_q_e6: got %b want 0000", bus.q); end
    n_cmp++; if (bus.cnt !== 8'd4) begin n_bad++; $display("FAIL t_cnt_e6: got %0d want 4", bus.cnt); end
    bus.ena = 1'b0; bus.load = 1'b1; bus.load_val = 4'hF;
    tick(3);
    n_cmp++; if (bus.q !== 4'b0000) begin n_bad++; $display("FAIL t_freeze_q: got %b want 0000", bus.q); end
    n_cmp++; if (bus.cnt !== 8'd4) begin n_bad++; $display("FAIL t_freeze_cnt: got %0d want 4", bus.cnt); end
    bus.load = 1'b0; bus.ena = 1'b1;
  endtask

  task automatic test_jk();
    do_reset();
    bus.load = 1'b1; bus.load_val = 4'b0011;
    tick(1);
    bus.load = 1'b0; bus.mode = 2'b10; bus.a = 4'b1100; bus.b = 4'b1010;
    tick(2);
    n_cmp++; if (bus.q !== 4'b0011) begin n_bad++; $display("FAIL jk_q_e2: got %b want 0011", bus.q); end
    tick(1);
    n_cmp++; if (bus.q !== 4'b1101) begin n_bad++; $display("FAIL jk_q_e3: got %b want 1101", bus.q); end
    tick(1);
    n_cmp++; if (bus.q !== 4'b0101) begin n_bad++; $display("FAIL jk_q_e4: got %b want 0101", bus.q); end
    n_cmp++; if (bus.cnt !== 8'd3) begin n_bad++; $display("FAIL jk_cnt: got %0d want 3", bus.cnt); end
  endtask

  task automatic test_sr();
    do_reset();
    bus.load = 1'b1; bus.load_val = 4'b1010;
    tick(1);
    bus.load = 1'b0; bus.mode = 2'b11; bus.a = 4'b0001; bus.b = 4'b0001;
    tick(2);
    n_cmp++; if (bus.sr_err !== 1'b0) begin n_bad++; $display("FAIL sr_err_e2: got %b want 0", bus.sr_err); end
    tick(1);
    n_cmp++; if (bus.sr_err !== 1'b1) begin n_bad++; $display("FAIL sr_err_e3: got %b want 1", bus.sr_err); end
    n_cmp++; if (bus.q !== 4'b1010) begin n_bad++; $display("FAIL sr_hold_q: got %b want 1010", bus.q); end
    bus.a = 4'b0100; bus.b = 4'b0010;
    tick(3);
    n_cmp++; if (bus.q !== 4'b1100) begin n_bad++; $display("FAIL sr_setclr_q: got %b want 1100", bus.q); end
    n_cmp++; if (bus.sr_err !== 1'b1) begin n_bad++; $display("FAIL sr_err_sticky: got %b want 1", bus.sr_err); end
    n_cmp++; if (bus.cnt !== 8'd2) begin n_bad++; $display("FAIL sr_cnt: got %0d want 2", bus.cnt); end
    bus.cnt_clr = 1'b1;
    tick(1);
    bus.cnt_clr = 1'b0;
    n_cmp++; if (bus.sr_err !== 1'b0) begin n_bad++; $display("FAIL sr_clr_err: got %b want 0", bus.sr_err); end
    n_cmp++; if (bus.cnt !== 8'd0) begin n_bad++; $display("FAIL sr_clr_cnt: got %0d want 0", bus.cnt); end
  endtask

  task automatic test_load();
    do_reset();
    bus.mode = 2'b01; bus.a = 4'hF; bus.load = 1'b1; bus.load_val = 4'b0110;
    tick(1);
    n_cmp++; if (bus.q !== 4'b0110) begin n_bad++; $display("FAIL ld_q: got %b want 0110", bus.q); end
    n_cmp++; if (bus.cnt !== 8'd1) begin n_bad++; $display("FAIL ld_cnt: got %0d want 1", bus.cnt); end
    tick(2);
    n_cmp++; if (bus.q !== 4'b0110) begin n_bad++; $display("FAIL ld_prio_q: got %b want 0110", bus.q); end
    n_cmp++; if (bus.cnt !== 8'd1) begin n_bad++; $display("FAIL ld_same_cnt: got %0d want 1", bus.cnt); end
    bus.load = 1'b0;
    tick(1);
    n_cmp++; if (bus.q !== 4'hF) begin n_bad++; $display("FAIL ld_release_q: got %h want F", bus.q); end
    n_cmp++; if (bus.cnt !== 8'd2) begin n_bad++; $display("FAIL ld_release_cnt: got %0d want 2", bus.cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.mode = 2'b00; bus.a = 4'b0001;
    tick(300);
    n_cmp++; if (bus.cnt !== 8'd255) begin n_bad++; $display("FAIL sat_cnt: got %0d want 255", bus.cnt); end
    tick(5);
    n_cmp++; if (bus.cnt !== 8'd255) begin n_bad++; $display("FAIL sat_hold: got %0d want 255", bus.cnt); end
    bus.cnt_clr = 1'b1;
    tick(1);
    bus.cnt_clr = 1'b0;
    n_cmp++; if (bus.cnt !== 8'd0) begin n_bad++; $display("FAIL sat_clr_prio: got %0d want 0", bus.cnt); end
    tick(1);
    n_cmp++; if (bus.cnt !== 8'd1) begin n_bad++; $display("FAIL sat_restart: got %0d want 1", bus.cnt); end
    bus.ena = 1'b0;
    tick(2);
    n_cmp++; if (bus.cnt !== 8'd1) begin n_bad++; $display("FAIL sat_ena0_hold: got %0d want 1", bus.cnt); end
    bus.cnt_clr = 1'b1;
    tick(1);
    bus.cnt_clr = 1'b0;
    n_cmp++; if (bus.cnt !== 8'd0) begin n_bad++; $display("FAIL sat_clr_ena0: got %0d want 0", bus.cnt); end
    bus.ena = 1'b1;
  endtask

  initial begin
    test_reset();
    test_t_mode();
    test_jk();
    test_sr();
    test_load();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
